// File: rtl/lint_2_apb_pkg.sv
// rtl/lint_2_apb_pkg.sv - shared types and constants for the LINT-to-APB bridge
package lint_2_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hBADACCE5;
    localparam logic [2:0]  APB_PPROT         = 3'b000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - base/mask address decoder, lowest matching slave wins
module apb_addr_decoder
    import lint_2_apb_pkg::*;
#(
    parameter int                              ADDR_WIDTH = 32,
    parameter int                              NB_SLAVES  = 4,
    parameter int                              IDX_W      = idx_width(NB_SLAVES),
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] ADDR_BASE  = '0,
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] ADDR_MASK  = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      idx_o
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                ADDR_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lint_2_apb_mslave.sv
// rtl/lint_2_apb_mslave.sv - single-outstanding LINT to multi-slave APB4 bridge
module lint_2_apb_mslave
    import lint_2_apb_pkg::*;
#(
    parameter int                              ADDR_WIDTH     = 32,
    parameter int                              DATA_WIDTH     = 32,
    parameter int                              BE_WIDTH       = DATA_WIDTH / 8,
    parameter int                              ID_WIDTH       = 10,
    parameter int                              AUX_WIDTH      = 8,
    parameter int                              NB_SLAVES      = 4,
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] ADDR_BASE      = '0,
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] ADDR_MASK      = '0,
    parameter int                              TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0]           ERR_RDATA      = DATA_WIDTH'(DEFAULT_ERR_RDATA)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            data_req_i,
    input  logic [ADDR_WIDTH-1:0]           data_add_i,
    input  logic                            data_wen_i,
    input  logic [DATA_WIDTH-1:0]           data_wdata_i,
    input  logic [BE_WIDTH-1:0]             data_be_i,
    input  logic [AUX_WIDTH-1:0]            data_aux_i,
    input  logic [ID_WIDTH-1:0]             data_ID_i,
    output logic                            data_gnt_o,
    output logic                            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
    output logic                            data_r_opc_o,
    output logic [AUX_WIDTH-1:0]            data_r_aux_o,
    output logic [ID_WIDTH-1:0]             data_r_ID_o,
    output logic [ADDR_WIDTH-1:0]           master_PADDR,
    output logic [DATA_WIDTH-1:0]           master_PWDATA,
    output logic                            master_PWRITE,
    output logic [BE_WIDTH-1:0]             master_PSTRB,
    output logic [2:0]                      master_PPROT,
    output logic [NB_SLAVES-1:0]            master_PSEL,
    output logic                            master_PENABLE,
    input  logic [NB_SLAVES*DATA_WIDTH-1:0] master_PRDATA,
    input  logic [NB_SLAVES-1:0]            master_PREADY,
    input  logic [NB_SLAVES-1:0]            master_PSLVERR,
    output logic                            err_decode_o,
    output logic                            err_timeout_o
);

    localparam int IDX_W   = idx_width(NB_SLAVES);
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [BE_WIDTH-1:0]     pstrb_q, pstrb_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AUX_WIDTH-1:0]    aux_q, aux_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   r_rdata_q, r_rdata_d;
    logic                    r_opc_q, r_opc_d;
    logic [AUX_WIDTH-1:0]    r_aux_q, r_aux_d;
    logic [ID_WIDTH-1:0]     r_id_q, r_id_d;
    logic                    err_dec_q, err_dec_d;
    logic                    err_to_q, err_to_d;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [DATA_WIDTH-1:0]   prdata_sel;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_SLAVES  (NB_SLAVES),
        .IDX_W      (IDX_W),
        .ADDR_BASE  (ADDR_BASE),
        .ADDR_MASK  (ADDR_MASK)
    ) u_decoder (
        .addr_i (data_add_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Only the registered target is observed, so other slaves cannot disturb the FSM.
    assign pready_sel  = master_PREADY[idx_q];
    assign pslverr_sel = master_PSLVERR[idx_q];
    assign prdata_sel  = master_PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        aux_d     = aux_q;
        id_d      = id_q;
        r_rdata_d = r_rdata_q;
        r_opc_d   = r_opc_q;
        r_aux_d   = r_aux_q;
        r_id_d    = r_id_q;
        err_dec_d = 1'b0;
        err_to_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    addr_d   = data_add_i;
                    wdata_d  = data_wdata_i;
                    pwrite_d = ~data_wen_i;
                    pstrb_d  = data_wen_i ? '0 : data_be_i;
                    aux_d    = data_aux_i;
                    id_d     = data_ID_i;
                    idx_d    = dec_idx;
                    cnt_d    = '0;
                    if (dec_hit) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d   = ST_RESP;
                        r_rdata_d = ERR_RDATA;
                        r_opc_d   = 1'b1;
                        r_aux_d   = data_aux_i;
                        r_id_d    = data_ID_i;
                        err_dec_d = 1'b1;
                    end
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_sel) begin
                    state_d   = ST_RESP;
                    r_rdata_d = prdata_sel;
                    r_opc_d   = pslverr_sel;
                    r_aux_d   = aux_q;
                    r_id_d    = id_q;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d   = ST_RESP;
                    r_rdata_d = ERR_RDATA;
                    r_opc_d   = 1'b1;
                    r_aux_d   = aux_q;
                    r_id_d    = id_q;
                    err_to_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            aux_q     <= '0;
            id_q      <= '0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            r_aux_q   <= '0;
            r_id_q    <= '0;
            err_dec_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            aux_q     <= aux_d;
            id_q      <= id_d;
            r_rdata_q <= r_rdata_d;
            r_opc_q   <= r_opc_d;
            r_aux_q   <= r_aux_d;
            r_id_q    <= r_id_d;
            err_dec_q <= err_dec_d;
            err_to_q  <= err_to_d;
        end
    end

    assign data_gnt_o     = (state_q == ST_IDLE);
    assign data_r_valid_o = (state_q == ST_RESP);
    assign data_r_rdata_o = r_rdata_q;
    assign data_r_opc_o   = r_opc_q;
    assign data_r_aux_o   = r_aux_q;
    assign data_r_ID_o    = r_id_q;
    assign master_PADDR   = addr_q;
    assign master_PWDATA  = wdata_q;
    assign master_PWRITE  = pwrite_q;
    assign master_PSTRB   = pstrb_q;
    assign master_PPROT   = APB_PPROT;
    assign master_PSEL    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ?
                            (NB_SLAVES'(1) << idx_q) : '0;
    assign master_PENABLE = (state_q == ST_ACCESS);
    assign err_decode_o   = err_dec_q;
    assign err_timeout_o  = err_to_q;

endmodule

// File: tb/tb_lint_2_apb_mslave.sv
// tb/tb_lint_2_apb_mslave.sv - directed bench for the LINT-to-APB bridge
module tb_lint_2_apb_mslave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 10;
    localparam int XW = 8;
    localparam int NS = 4;
    localparam logic [NS*AW-1:0] BASES = {32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000};
    localparam logic [NS*AW-1:0] MASKS = {4{32'hFFFF_F000}};
    localparam logic [31:0]      ERR   = 32'hBADACCE5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              data_req;
    logic [AW-1:0]     data_add;
    logic              data_wen;
    logic [DW-1:0]     data_wdata;
    logic [BW-1:0]     data_be;
    logic [XW-1:0]     data_aux;
    logic [IW-1:0]     data_id;
    logic              data_gnt;
    logic              r_valid;
    logic [DW-1:0]     r_rdata;
    logic              r_opc;
    logic [XW-1:0]     r_aux;
    logic [IW-1:0]     r_id;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic [BW-1:0]     pstrb;
    logic [2:0]        pprot;
    logic [NS-1:0]     psel;
    logic              penable;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
    logic [NS-1:0]     pslverr;
    logic              err_dec;
    logic              err_to;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lint_2_apb_mslave #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BE_WIDTH       (BW),
        .ID_WIDTH       (IW),
        .AUX_WIDTH      (XW),
        .NB_SLAVES      (NS),
        .ADDR_BASE      (BASES),
        .ADDR_MASK      (MASKS),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (data_req),
        .data_add_i     (data_add),
        .data_wen_i     (data_wen),
        .data_wdata_i   (data_wdata),
        .data_be_i      (data_be),
        .data_aux_i     (data_aux),
        .data_ID_i      (data_id),
        .data_gnt_o     (data_gnt),
        .data_r_valid_o (r_valid),
        .data_r_rdata_o (r_rdata),
        .data_r_opc_o   (r_opc),
        .data_r_aux_o   (r_aux),
        .data_r_ID_o    (r_id),
        .master_PADDR   (paddr),
        .master_PWDATA  (pwdata),
        .master_PWRITE  (pwrite),
        .master_PSTRB   (pstrb),
        .master_PPROT   (pprot),
        .master_PSEL    (psel),
        .master_PENABLE (penable),
        .master_PRDATA  (prdata),
        .master_PREADY  (pready),
        .master_PSLVERR (pslverr),
        .err_decode_o   (err_dec),
        .err_timeout_o  (err_to)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic wen, input logic [DW-1:0] wd,
                             input logic [BW-1:0] be, input logic [XW-1:0] aux, input logic [IW-1:0] id);
        data_req   = 1'b1;
        data_add   = a;
        data_wen   = wen;
        data_wdata = wd;
        data_be    = be;
        data_aux   = aux;
        data_id    = id;
    endtask

    initial begin
        rst_n = 1'b0;
        data_req = 1'b0; data_add = '0; data_wen = 1'b0; data_wdata = '0;
        data_be = '0; data_aux = '0; data_id = '0;
        prdata = '0; pready = '0; pslverr = '0;
        step();
        step();
        check("rst_gnt",    data_gnt, 1);
        check("rst_valid",  r_valid, 0);
        check("rst_psel",   psel, 0);
        check("rst_pen",    penable, 0);
        check("rst_pprot",  pprot, 0);
        check("rst_rdata",  r_rdata, 0);
        rst_n = 1'b1;
        step();

        // zero-wait read to slave 2
        prdata[2*DW +: DW] = 32'h1234_5678;
        pready = 4'b0100;
        drive_req(32'h4000_2010, 1'b1, 32'hFFFF_FFFF, 4'hF, 8'h5A, 10'h155);
        check("rd_c0_gnt", data_gnt, 1);
        step();
        data_req = 1'b0;
        check("rd_c1_psel",  psel, 4'b0100);
        check("rd_c1_pen",   penable, 0);
        check("rd_c1_pstrb", pstrb, 0);
        check("rd_c1_pwr",   pwrite, 0);
        check("rd_c1_paddr", paddr, 32'h4000_2010);
        step();
        check("rd_c2_psel",  psel, 4'b0100);
        check("rd_c2_pen",   penable, 1);
        check("rd_c2_valid", r_valid, 0);
        step();
        check("rd_c3_valid", r_valid, 1);
        check("rd_c3_rdata", r_rdata, 32'h1234_5678);
        check("rd_c3_opc",   r_opc, 0);
        check("rd_c3_id",    r_id, 10'h155);
        check("rd_c3_aux",   r_aux, 8'h5A);
        check("rd_c3_gnt",   data_gnt, 0);
        check("rd_c3_psel",  psel, 0);
        step();
        check("rd_c4_gnt",   data_gnt, 1);
        check("rd_c4_valid", r_valid, 0);
        check("rd_c4_hold",  r_rdata, 32'h1234_5678);

        // write to slave 0, PREADY after three wait cycles; other slaves ready but ignored
        pready = 4'b1110;
        drive_req(32'h4000_0004, 1'b0, 32'hCAFE_F00D, 4'b0011, 8'h11, 10'h022);
        step();
        data_req = 1'b0;
        check("wr_c1_pstrb",  pstrb, 4'b0011);
        check("wr_c1_pwrite", pwrite, 1);
        check("wr_c1_pwdata", pwdata, 32'hCAFE_F00D);
        check("wr_c1_psel",   psel, 4'b0001);
        step();
        check("wr_c2_pen",    penable, 1);
        step();
        step();
        check("wr_c4_pen",    penable, 1);
        check("wr_c4_valid",  r_valid, 0);
        check("wr_c4_pstrb",  pstrb, 4'b0011);
        step();
        pready = 4'b1111;
        check("wr_c5_pen",    penable, 1);
        step();
        check("wr_c6_valid",  r_valid, 1);
        check("wr_c6_opc",    r_opc, 0);
        check("wr_c6_id",     r_id, 10'h022);
        pready = '0;
        step();

        // slave error from slave 1
        prdata[1*DW +: DW] = 32'hA5A5_0001;
        pready  = 4'b0010;
        pslverr = 4'b0010;
        drive_req(32'h4000_1000, 1'b1, '0, 4'hF, 8'h33, 10'h3FF);
        step();
        data_req = 1'b0;
        step();
        step();
        check("se_valid", r_valid, 1);
        check("se_opc",   r_opc, 1);
        check("se_rdata", r_rdata, 32'hA5A5_0001);
        check("se_id",    r_id, 10'h3FF);
        pslverr = '0;
        pready  = '0;
        step();

        // decode miss
        drive_req(32'h5000_0000, 1'b1, '0, 4'hF, 8'h44, 10'h0AA);
        step();
        data_req = 1'b0;
        check("dm_valid", r_valid, 1);
        check("dm_opc",   r_opc, 1);
        check("dm_rdata", r_rdata, ERR);
        check("dm_err",   err_dec, 1);
        check("dm_psel",  psel, 0);
        check("dm_id",    r_id, 10'h0AA);
        step();
        check("dm_err_end", err_dec, 0);
        check("dm_valid_end", r_valid, 0);
        check("dm_gnt", data_gnt, 1);

        // timeout on slave 3
        pready = '0;
        drive_req(32'h4000_3000, 1'b1, '0, 4'hF, 8'h55, 10'h101);
        step();
        data_req = 1'b0;
        repeat (8) step();
        check("to_c9_psel",  psel, 4'b1000);
        check("to_c9_pen",   penable, 1);
        check("to_c9_err",   err_to, 0);
        check("to_c9_valid", r_valid, 0);
        step();
        check("to_c10_valid", r_valid, 1);
        check("to_c10_opc",   r_opc, 1);
        check("to_c10_rdata", r_rdata, ERR);
        check("to_c10_err",   err_to, 1);
        check("to_c10_psel",  psel, 0);
        step();
        check("to_c11_err",   err_to, 0);
        pready = 4'b1000;
        prdata[3*DW +: DW] = 32'hDEAD_BEEF;
        repeat (3) step();
        check("to_late_valid", r_valid, 0);
        check("to_late_rdata", r_rdata, ERR);
        check("to_late_gnt",   data_gnt, 1);
        pready = '0;

        // reset while in ACCESS, then a back-to-back request
        drive_req(32'h4000_1008, 1'b1, '0, 4'hF, 8'h66, 10'h0F0);
        step();
        data_req = 1'b0;
        step();
        check("mr_c2_psel", psel, 4'b0010);
        check("mr_c2_pen",  penable, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_psel",  psel, 0);
        check("mr_pen",   penable, 0);
        check("mr_gnt",   data_gnt, 1);
        check("mr_valid", r_valid, 0);
        check("mr_rdata", r_rdata, 0);
        pready = 4'b0010;
        prdata[1*DW +: DW] = 32'h1111_2222;
        drive_req(32'h4000_1008, 1'b1, '0, 4'hF, 8'h77, 10'h0F1);
        step();
        data_req = 1'b0;
        check("b2b_c1_valid", r_valid, 0);
        check("b2b_c1_psel",  psel, 4'b0010);
        step();
        step();
        check("b2b_c3_valid", r_valid, 1);
        check("b2b_c3_rdata", r_rdata, 32'h1111_2222);
        check("b2b_c3_opc",   r_opc, 0);
        check("b2b_c3_aux",   r_aux, 8'h77);
        pready = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lint_2_apb_mslave.md
Name: lint_2_apb_mslave

Overview:
- Parametrised successor of the single-port LINT-to-APB bridge; sits between a TCDM/LINT interconnect master port and a set of APB peripherals.
- Accepts one LINT request at a time and decodes it to one of NB_SLAVES APB4 slaves.
- Runs a full APB SETUP/ACCESS sequence and returns a single LINT response.
- Adds APB4 PSTRB/PPROT, a decode-miss error path and a programmable PREADY timeout.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable / PSTRB width.
- ID_WIDTH, 10, LINT transaction ID width.
- AUX_WIDTH, 8, LINT aux width.
- NB_SLAVES, 4, number of APB slave ports (1..16).
- ADDR_BASE, 0, packed NB_SLAVES*ADDR_WIDTH base addresses; slave i occupies slice i.
- ADDR_MASK, 0, packed NB_SLAVES*ADDR_WIDTH decode masks.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; 0 disables the timeout.
- ERR_RDATA, 32'hBADACCE5, rdata returned on decode miss or timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- data_req_i  in  1  LINT request
- data_add_i  in  ADDR_WIDTH  address
- data_wen_i  in  1  1=read, 0=write
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_aux_i  in  AUX_WIDTH  aux, echoed
- data_ID_i  in  ID_WIDTH  ID, echoed
- data_gnt_o  out  1  grant
- data_r_valid_o  out  1  response valid
- data_r_rdata_o  out  DATA_WIDTH  read data
- data_r_opc_o  out  1  1=error
- data_r_aux_o  out  AUX_WIDTH  echoed aux
- data_r_ID_o  out  ID_WIDTH  echoed ID
- master_PADDR  out  ADDR_WIDTH  shared address
- master_PWDATA  out  DATA_WIDTH  shared write data
- master_PWRITE  out  1  shared direction
- master_PSTRB  out  BE_WIDTH  write strobes
- master_PPROT  out  3  fixed 3'b000
- master_PSEL  out  NB_SLAVES  one-hot select
- master_PENABLE  out  1  shared enable
- master_PRDATA  in  NB_SLAVES*DATA_WIDTH  packed read data
- master_PREADY  in  NB_SLAVES  per-slave ready
- master_PSLVERR  in  NB_SLAVES  per-slave error
- err_decode_o  out  1  one-cycle pulse on decode miss
- err_timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: one clock, synchronous, active-low. All registers clear on a clk edge with rst_n=0, including mid-transfer; PSEL/PENABLE are 0 from that edge, with no response and no completion of the aborted access.
- Outputs are 0 after reset, except data_gnt_o=1 (state IDLE).
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - data_gnt_o=1.
  - On data_req_i, sample addr, wdata, ~wen→PWRITE, aux and ID.
  - Sample PSTRB = be on a write, 0 on a read.
  - Register the decoded slave index.
  - Decode hit → SETUP. Decode miss → RESP with opc=1, rdata=ERR_RDATA, err_decode_o pulses; no PSEL is raised.
- Decode rule: slave i hits when (addr & MASK[i]) == BASE[i]. Lowest index wins on overlap.
- SETUP: PSEL[idx]=1, PENABLE=0; always → ACCESS after 1 cycle.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - If PREADY[idx]: capture PRDATA slice idx into rdata (on writes as well) and PSLVERR[idx] into opc; → RESP.
  - Else increment the wait counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY low: opc=1, rdata=ERR_RDATA, err_timeout_o pulses, → RESP.
  - On timeout, PSEL/PENABLE drop at the next edge; a later PREADY is ignored.
- RESP: data_r_valid_o=1 for exactly one cycle, data_gnt_o=0; → IDLE.
- The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- Latency with a zero-wait slave: req granted in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, r_valid in cycle 3, next grant in cycle 4.
- A decode miss gives r_valid in cycle 1.
- PADDR, PWDATA, PWRITE and PSTRB stay stable from SETUP through the end of ACCESS.
- Response outputs hold their values until the next sampled response.
- PREADY/PRDATA of non-selected slaves never affect state.
- Sampling: data_req_i is only sampled in IDLE, and only one transaction is outstanding at a time.

Decomposition:
- Package lint_2_apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default ERR_RDATA, PPROT constant.
- Sub-module apb_addr_decoder: combinational; takes addr, ADDR_BASE and ADDR_MASK; outputs hit and a clog2(NB_SLAVES) index.

Test Plan:
- Zero-wait read: read at BASE[2] with PRDATA[2]=32'h1234_5678 → PSEL=4'b0100 in cycles 1–2, PENABLE in cycle 2, r_valid in cycle 3 with rdata=32'h12345678, opc=0, ID/aux echoed.
- Write with be=4'b0011, wdata=32'hCAFEF00D to slave 0 with PREADY delayed 3 cycles → PSTRB=4'b0011, PWRITE=1, ACCESS lasts 4 cycles, r_valid in cycle 6, opc=0.
- PSLVERR: slave 1 returns PSLVERR=1 → opc=1, rdata=slave 1's PRDATA.
- Decode miss: address outside all windows → no PSEL, r_valid in cycle 1, opc=1, rdata=ERR_RDATA, err_decode_o pulses once.
- Timeout (TIMEOUT_CYCLES=8): PREADY held low → PSEL drops after 8 ACCESS cycles, opc=1, err_timeout_o pulses; a later PREADY on that slave has no effect.
- Reset mid-ACCESS: rst_n=0 for 1 edge → PSEL=0 and gnt=1 next cycle, no r_valid; a back-to-back request afterwards completes normally.
